// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial adder.
// State encoding, slice width and index-width helper.
package nsa_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int NIBBLE_W = 4;

   // Never returns 0 so a single-nibble adder still gets a 1-bit index.
   function automatic int clog2(input int n);
      int r;
      r = 1;
      while ((1 << r) < n)
         r = r + 1;
      return r;
   endfunction

endpackage

// File: rtl/cla4_slice.sv
// 4-bit carry-lookahead slice, the arithmetic core of the adder.
// Also exports the carry into bit 3 for overflow detection.
module cla4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout,
   output logic       c3
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0])
               | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign s    = p ^ c[3:0];
   assign cout = c[4];
   assign c3   = c[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder: one nibble per clock through a CLA slice,
// carry registered between nibbles, start/done handshake.
module nibble_serial_adder
   import nsa_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                   CLK,
   input  logic                   RST_n,
   input  logic                   Start,
   input  logic [4*NIBBLES-1:0]   A,
   input  logic [4*NIBBLES-1:0]   B,
   input  logic                   Cin,
   output logic                   Busy,
   output logic                   Done,
   output logic [4*NIBBLES-1:0]   S,
   output logic                   Cout,
   output logic                   Ovf
);

   localparam int W  = NIBBLE_W * NIBBLES;
   localparam int IW = clog2(NIBBLES);

   state_e         state_q, state_d;
   logic [W-1:0]   a_q, b_q, s_q, s_d;
   logic [IW-1:0]  idx_q;
   logic           c_q, cout_q, ovf_q;

   logic [3:0]     a_nib, b_nib, sum_nib;
   logic           sl_cout, sl_c3;
   logic           accept, last;

   // Start is only honoured outside RUN, which also covers back-to-back.
   assign accept = Start && (state_q != RUN);
   assign last   = (idx_q == IW'(NIBBLES - 1));

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = Start ? RUN : IDLE;
         RUN:     state_d = last ? DONE : RUN;
         DONE:    state_d = Start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      Busy = (state_q == RUN);
      Done = (state_q == DONE);
   end

   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IW'(i)) begin
            a_nib = a_q[4*i +: 4];
            b_nib = b_q[4*i +: 4];
         end
      end
   end

   cla4_slice u_slice (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (c_q),
      .s    (sum_nib),
      .cout (sl_cout),
      .c3   (sl_c3)
   );

   always_comb begin
      s_d = s_q;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IW'(i))
            s_d[4*i +: 4] = sum_nib;
      end
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         a_q    <= '0;
         b_q    <= '0;
         s_q    <= '0;
         idx_q  <= '0;
         c_q    <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         a_q    <= A;
         b_q    <= B;
         s_q    <= '0;
         idx_q  <= '0;
         c_q    <= Cin;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (state_q == RUN) begin
         s_q <= s_d;
         c_q <= sl_cout;
         if (last) begin
            cout_q <= sl_cout;
            ovf_q  <= sl_c3 ^ sl_cout;
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   assign S    = s_q;
   assign Cout = cout_q;
   assign Ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder with NIBBLES = 4.
// Expected sums come from a behavioural 17-bit add model.
module tb_nibble_serial_adder;

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        o;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST_n = 1'b0;
   logic        Start = 1'b0;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic        Cin = 1'b0;
   logic        Busy, Done, Cout, Ovf;
   logic [15:0] S;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   nibble_serial_adder #(.NIBBLES(4)) dut (
      .CLK   (CLK),
      .RST_n (RST_n),
      .Start (Start),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .Busy  (Busy),
      .Done  (Done),
      .S     (S),
      .Cout  (Cout),
      .Ovf   (Ovf)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   function automatic exp_t model(input logic [15:0] a,
                                  input logic [15:0] b,
                                  input logic cin);
      exp_t        e;
      logic [16:0] full;
      logic [15:0] low;
      full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      low  = {1'b0, a[14:0]} + {1'b0, b[14:0]} + {15'd0, cin};
      e.s = full[15:0];
      e.c = full[16];
      e.o = low[15] ^ full[16];
      return e;
   endfunction

   // Drops Start after the accepting edge and counts cycles to Done.
   task automatic wait_done(output int cyc, output int busy_n);
      cyc    = -1;
      busy_n = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge CLK);
         Start = 1'b0;
         if (Done) begin
            cyc = n;
            break;
         end
         if (Busy) busy_n++;
      end
   endtask

   task automatic test_reset();
      RST_n = 1'b1;
      repeat (2) @(negedge CLK);
      @(posedge CLK);
      #3 RST_n = 1'b0;
      #1;
      checks++;
      if ({Busy, Done, S, Cout, Ovf} !== 19'd0) begin
         errors++;
         $display("FAIL reset_vals got %b %b %h %b %b want 0 0 0000 0 0",
                  Busy, Done, S, Cout, Ovf);
      end
      @(negedge CLK);
      RST_n = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_add(input logic [15:0] a, input logic [15:0] b,
                           input logic cin);
      int   cyc, bn;
      exp_t e;
      @(negedge CLK);
      Start = 1'b1;
      A = a;
      B = b;
      Cin = cin;
      sb.push_back(model(a, b, cin));
      wait_done(cyc, bn);
      e = sb.pop_front();
      checks++;
      if (cyc != 5 || bn != 4) begin
         errors++;
         $display("FAIL add_timing %h+%h got done@%0d busy=%0d want 5 4",
                  a, b, cyc, bn);
      end
      checks++;
      if (S !== e.s || Cout !== e.c || Ovf !== e.o) begin
         errors++;
         $display("FAIL add_result %h+%h+%b got %h %b %b want %h %b %b",
                  a, b, cin, S, Cout, Ovf, e.s, e.c, e.o);
      end
      @(negedge CLK);
      checks++;
      if (Done !== 1'b0 || Busy !== 1'b0 || S !== e.s || Cout !== e.c) begin
         errors++;
         $display("FAIL idle_hold got done=%b busy=%b S=%h c=%b want 0 0 %h %b",
                  Done, Busy, S, Cout, e.s, e.c);
      end
   endtask

   task automatic test_back_to_back();
      int   cyc, bn;
      exp_t e;
      @(negedge CLK);
      Start = 1'b1;
      A = 16'h1111;
      B = 16'h2222;
      Cin = 1'b0;
      sb.push_back(model(16'h1111, 16'h2222, 1'b0));
      for (int n = 0; n < 4; n++) begin
         @(negedge CLK);
         A = 16'($urandom);
         B = 16'($urandom);
         Cin = 1'($urandom);
         checks++;
         if (Busy !== 1'b1 || Done !== 1'b0) begin
            errors++;
            $display("FAIL held_start_busy n=%0d got %b %b want 1 0",
                     n, Busy, Done);
         end
      end
      @(negedge CLK);
      e = sb.pop_front();
      checks++;
      if (Done !== 1'b1 || S !== e.s || Cout !== e.c || Ovf !== e.o) begin
         errors++;
         $display("FAIL held_start_result got d=%b %h %b %b want 1 %h %b %b",
                  Done, S, Cout, Ovf, e.s, e.c, e.o);
      end
      A = 16'h0F0F;
      B = 16'hF0F0;
      Cin = 1'b1;
      sb.push_back(model(16'h0F0F, 16'hF0F0, 1'b1));
      wait_done(cyc, bn);
      e = sb.pop_front();
      checks++;
      if (cyc != 5 || bn != 4) begin
         errors++;
         $display("FAIL b2b_timing got done@%0d busy=%0d want 5 4", cyc, bn);
      end
      checks++;
      if (S !== e.s || Cout !== e.c || Ovf !== e.o) begin
         errors++;
         $display("FAIL b2b_result got %h %b %b want %h %b %b",
                  S, Cout, Ovf, e.s, e.c, e.o);
      end
      @(negedge CLK);
   endtask

   task automatic test_reset_abort();
      int seen;
      @(negedge CLK);
      Start = 1'b1;
      A = 16'hAAAA;
      B = 16'h1111;
      Cin = 1'b0;
      @(negedge CLK);
      Start = 1'b0;
      @(posedge CLK);
      #2 RST_n = 1'b0;
      #1;
      checks++;
      if ({Busy, Done, S, Cout, Ovf} !== 19'd0) begin
         errors++;
         $display("FAIL abort_vals got %b %b %h %b %b want 0 0 0000 0 0",
                  Busy, Done, S, Cout, Ovf);
      end
      @(negedge CLK);
      RST_n = 1'b1;
      seen = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge CLK);
         if (Done || Busy) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL abort_no_done got %0d active cycles want 0", seen);
      end
      test_add(16'h8000, 16'h8000, 1'b0);
   endtask

   initial begin
      test_reset();
      test_add(16'h1234, 16'h4321, 1'b0);
      test_add(16'hFFFF, 16'h0000, 1'b1);
      test_add(16'h7FFF, 16'h0001, 1'b0);
      test_back_to_back();
      test_reset_abort();
      for (int i = 0; i < 6; i++)
         test_add(16'($urandom), 16'($urandom), 1'($urandom));
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got %0d want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
